// File: rtl/mux_scanner_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_scanner_pkg
// Description : Shared state encoding and parameter defaults for mux_scanner.
// Revision    : 1.0 - initial release
// ============================================================================
package mux_scanner_pkg;

    localparam int c_CH_DEFAULT    = 2;
    localparam int c_SEL_W_DEFAULT = 2;
    localparam int c_DWELL_DEFAULT = 4;
    localparam int c_DWELL_W       = 8;

    typedef enum logic [0:0] {
        DIRECT = 1'b0,
        SCAN   = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/scan_counter.sv
`default_nettype none
// ============================================================================
// Module      : scan_counter
// Description : Dwell and address counters with load, hold and wrap pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module scan_counter
    import mux_scanner_pkg::*;
#(
    parameter int SEL_W = c_SEL_W_DEFAULT,
    parameter int DWELL = c_DWELL_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_mode,
    input  logic             i_scan_active,
    input  logic [SEL_W-1:0] i_sel,
    input  logic             i_load,
    input  logic             i_hold,
    output logic [SEL_W-1:0] o_addr,
    output logic [SEL_W-1:0] o_addr_next,
    output logic             o_wrap
);

    localparam logic [c_DWELL_W-1:0] c_DWELL_LAST = c_DWELL_W'(DWELL - 1);
    localparam logic [SEL_W-1:0]     c_ADDR_LAST  = '1;

    logic [SEL_W-1:0]     r_addr;
    logic [c_DWELL_W-1:0] r_dwell;
    logic                 r_wrap;

    logic [SEL_W-1:0]     w_addr_next;
    logic [c_DWELL_W-1:0] w_dwell_next;
    logic                 w_wrap_next;

    // The first scan cycle after leaving DIRECT only restarts dwell; load is
    // honoured once the state register itself reports SCAN.
    always_comb begin
        w_addr_next  = r_addr;
        w_dwell_next = r_dwell;
        w_wrap_next  = 1'b0;
        if (!i_mode) begin
            w_addr_next  = i_sel;
            w_dwell_next = '0;
        end else if (!i_scan_active) begin
            w_dwell_next = '0;
        end else if (i_load) begin
            w_addr_next  = i_sel;
            w_dwell_next = '0;
        end else if (!i_hold) begin
            if (r_dwell == c_DWELL_LAST) begin
                w_dwell_next = '0;
                w_addr_next  = r_addr + 1'b1;
                w_wrap_next  = (r_addr == c_ADDR_LAST);
            end else begin
                w_dwell_next = r_dwell + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_dwell <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_addr  <= w_addr_next;
            r_dwell <= w_dwell_next;
            r_wrap  <= w_wrap_next;
        end
    end

    assign o_addr      = r_addr;
    assign o_addr_next = w_addr_next;
    assign o_wrap      = r_wrap;

endmodule
`default_nettype wire

// File: rtl/mux_scanner.sv
`default_nettype none
// ============================================================================
// Module      : mux_scanner
// Description : Multi-channel N:1 selector with direct and auto-scan modes.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_scanner
    import mux_scanner_pkg::*;
#(
    parameter int CH    = c_CH_DEFAULT,
    parameter int SEL_W = c_SEL_W_DEFAULT,
    parameter int DWELL = c_DWELL_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [CH-1:0]               en_n,
    input  logic                        mode,
    input  logic [SEL_W-1:0]            sel_in,
    input  logic                        load,
    input  logic                        hold,
    input  logic [CH*(2**SEL_W)-1:0]    d,
    output logic [CH-1:0]               y,
    output logic [SEL_W-1:0]            addr,
    output logic                        wrap
);

    localparam int c_N = 2**SEL_W;

    state_t           r_state;
    logic [CH-1:0]    r_y;
    logic [SEL_W-1:0] w_addr_next;
    logic [CH-1:0]    w_sel_bit;

    scan_counter #(
        .SEL_W (SEL_W),
        .DWELL (DWELL)
    ) u_scan_counter (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_mode        (mode),
        .i_scan_active (r_state == SCAN),
        .i_sel         (sel_in),
        .i_load        (load),
        .i_hold        (hold),
        .o_addr        (addr),
        .o_addr_next   (w_addr_next),
        .o_wrap        (wrap)
    );

    // Selecting with the next address keeps y aligned with the registered addr.
    generate
        for (genvar g = 0; g < CH; g++) begin : g_chan
            logic [c_N-1:0] w_ch;
            assign w_ch         = d[g*c_N +: c_N];
            assign w_sel_bit[g] = w_ch[w_addr_next];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= DIRECT;
            r_y     <= '0;
        end else begin
            r_state <= mode ? SCAN : DIRECT;
            r_y     <= w_sel_bit & ~en_n;
        end
    end

    assign y = r_y;

endmodule
`default_nettype wire

// File: tb/tb_mux_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_scanner
// Description : Scoreboard bench for mux_scanner with directed and random runs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_scanner;

    localparam int CH    = 2;
    localparam int SEL_W = 2;
    localparam int DWELL = 4;
    localparam int N     = 4;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [CH-1:0]       en_n;
    logic                mode;
    logic [SEL_W-1:0]    sel_in;
    logic                load;
    logic                hold;
    logic [CH*N-1:0]     d;
    logic [CH-1:0]       y;
    logic [SEL_W-1:0]    addr;
    logic                wrap;

    typedef struct packed {
        logic [CH-1:0]    y;
        logic [SEL_W-1:0] addr;
        logic             wrap;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   m_addr;
    int   m_dwell;
    bit   m_scan;

    mux_scanner #(
        .CH    (CH),
        .SEL_W (SEL_W),
        .DWELL (DWELL)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_n   (en_n),
        .mode   (mode),
        .sel_in (sel_in),
        .load   (load),
        .hold   (hold),
        .d      (d),
        .y      (y),
        .addr   (addr),
        .wrap   (wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s t=%0t got=%0d want=%0d", name, $time, got, want);
        end
    endtask

    task automatic model_reset();
        m_addr  = 0;
        m_dwell = 0;
        m_scan  = 1'b0;
    endtask

    // One clock of stimulus; optionally pulses reset between edges first.
    task automatic step(input bit md, input int sel, input bit ld, input bit hd,
                        input logic [CH-1:0] en, input logic [CH*N-1:0] dv,
                        input bit pulse);
        exp_t e;
        bit   w;
        @(negedge clk);
        if (pulse) begin
            #1 rst_n = 1'b0;
            #1;
            check("async_y", int'(y), 0);
            check("async_addr", int'(addr), 0);
            check("async_wrap", int'(wrap), 0);
            #1 rst_n = 1'b1;
            model_reset();
        end
        mode   = md;
        sel_in = sel[SEL_W-1:0];
        load   = ld;
        hold   = hd;
        en_n   = en;
        d      = dv;
        w      = 1'b0;
        if (!md) begin
            m_addr  = sel % N;
            m_dwell = 0;
        end else if (!m_scan) begin
            m_dwell = 0;
        end else if (ld) begin
            m_addr  = sel % N;
            m_dwell = 0;
        end else if (!hd) begin
            if (m_dwell == DWELL - 1) begin
                m_dwell = 0;
                w       = (m_addr == N - 1);
                m_addr  = (m_addr + 1) % N;
            end else begin
                m_dwell++;
            end
        end
        m_scan = md;
        for (int c = 0; c < CH; c++) e.y[c] = dv[c*N + m_addr] & ~en[c];
        e.addr = m_addr[SEL_W-1:0];
        e.wrap = w;
        q.push_back(e);
    endtask

    task automatic scan_step();
        step(1'b1, 0, 1'b0, 1'b0, 2'b00, 8'b1010_1010, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("y", int'(y), int'(e.y));
                check("addr", int'(addr), int'(e.addr));
                check("wrap", int'(wrap), int'(e.wrap));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog t=%0t got=timeout want=finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        en_n   = '0;
        mode   = 1'b0;
        sel_in = '0;
        load   = 1'b0;
        hold   = 1'b0;
        d      = '0;
        model_reset();
        #3;
        check("reset_y", int'(y), 0);
        check("reset_addr", int'(addr), 0);
        check("reset_wrap", int'(wrap), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Direct select with channel 1 disabled; load/hold must be ignored.
        for (int i = 0; i < 4; i++) step(1'b0, i, 1'b0, 1'b0, 2'b10, 8'b1010_1010, 1'b0);
        step(1'b0, 1, 1'b1, 1'b1, 2'b10, 8'b1010_1010, 1'b0);

        // Full scan from address 0 through one wrap.
        step(1'b0, 0, 1'b0, 1'b0, 2'b00, 8'b1010_1010, 1'b0);
        repeat (20) scan_step();

        // Load at dwell 2.
        for (int i = 0; i < 8 && m_dwell != 2; i++) scan_step();
        step(1'b1, 2, 1'b1, 1'b0, 2'b00, 8'b1010_1010, 1'b0);
        repeat (6) scan_step();

        // Hold at address 3, then release.
        for (int i = 0; i < 20 && m_addr != 3; i++) scan_step();
        repeat (10) step(1'b1, 0, 1'b0, 1'b1, 2'b00, 8'b1010_1010, 1'b0);
        repeat (6) scan_step();

        // Load and hold together.
        step(1'b1, 1, 1'b1, 1'b1, 2'b00, 8'b1010_1010, 1'b0);
        repeat (3) scan_step();

        // Asynchronous reset mid-scan, then back to direct.
        repeat (5) scan_step();
        step(1'b1, 0, 1'b0, 1'b0, 2'b00, 8'b1010_1010, 1'b1);
        repeat (5) scan_step();
        step(1'b0, 2, 1'b0, 1'b0, 2'b01, 8'b0110_1001, 1'b0);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) != 0, int'($urandom_range(0, N - 1)),
                 $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
                 CH'($urandom), (CH*N)'($urandom), $urandom_range(0, 63) == 0);
        end

        repeat (2) @(negedge clk);
        check("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mux_scanner.md
MUX_SCANNER -- requirements
Module: mux_scanner

Interface
REQ-001 Parameter CH, default 2: number of independent selector channels.
REQ-002 Parameter SEL_W, default 2: select width; each channel has N = 2**SEL_W data inputs.
REQ-003 Parameter DWELL, default 4: cycles spent on each address in scan mode; legal range 1..255.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 en_n  input  CH  per-channel strobe, active-low; high forces that channel's y to 0.
REQ-007 mode  input  1  0 = direct select, 1 = auto-scan.
REQ-008 sel_in  input  SEL_W  select address in direct mode; start address on load.
REQ-009 load  input  1  scan mode only: load address counter from sel_in.
REQ-010 hold  input  1  scan mode only: freeze address and dwell counters.
REQ-011 d  input  CH*N  flattened data; channel c, input i at bit c*N+i.
REQ-012 y  output  CH  registered selected bit per channel.
REQ-013 addr  output  SEL_W  registered address used for the current y.
REQ-014 wrap  output  1  one-cycle pulse when the scan address wraps from N-1 to 0.

Function
REQ-015 The block SHALL have two states: DIRECT (mode=0) and SCAN (mode=1); the state register SHALL follow mode with a one-cycle delay.
REQ-016 In DIRECT, each cycle: addr <= sel_in; y[c] <= d[c*N+sel_in] AND NOT en_n[c]; latency 1 cycle.
REQ-017 In SCAN, y[c] SHALL be d[c*N+addr_next] AND NOT en_n[c], registered together with addr, so y always matches addr.
REQ-018 In SCAN, the dwell counter SHALL count 0..DWELL-1; at DWELL-1 it SHALL return to 0 and addr SHALL increment modulo N.
REQ-019 wrap SHALL pulse high for exactly one cycle, in the same cycle addr changes from N-1 to 0 by increment; load SHALL NOT assert wrap.
REQ-020 load in SCAN SHALL set addr <= sel_in and dwell <= 0, and SHALL take priority over both increment and hold.
REQ-021 hold in SCAN (without load) SHALL freeze addr and dwell; y SHALL continue sampling d at the frozen addr.
REQ-022 On a DIRECT->SCAN transition, addr SHALL be retained, and dwell SHALL restart at 0.
REQ-023 On a SCAN->DIRECT transition, dwell SHALL clear to 0 and wrap SHALL be 0.
REQ-024 load and hold SHALL be ignored in DIRECT.
REQ-025 en_n SHALL gate only y, never addr, dwell or wrap.
REQ-026 With DWELL=1, addr SHALL advance every cycle.
REQ-027 With SEL_W=1, wrap SHALL fire every 2*DWELL cycles.

Reset
REQ-028 While rst_n=0: y=0, addr=0, wrap=0, dwell=0, state=DIRECT, all taking effect immediately and independently of clk.
REQ-029 rst_n asserted mid-scan SHALL abort the scan; after release, the first edge SHALL behave per mode, with SCAN resuming from addr 0 and dwell 0.

Structure
REQ-030 Package mux_scanner_pkg SHALL hold the state enum (DIRECT, SCAN) and the parameter defaults.
REQ-031 Sub-module scan_counter SHALL own the dwell and address counters, load, hold and wrap generation.
REQ-032 The per-channel select-and-gate logic SHALL be a generate loop over CH in the top level.

Verification (CH=2, SEL_W=2, DWELL=4, d=8'b1010_1010)
REQ-033 The bench SHALL cover DIRECT with en_n=2'b10 and sel_in stepping 0,1,2,3 -> y[0]=0,1,0,1 one cycle later each; y[1]=0 throughout.
REQ-034 The bench SHALL cover SCAN from addr 0 with en_n=0 -> addr holds each value for 4 cycles; y=2'b00,2'b11,2'b00,2'b11; wrap high for one cycle at cycle 16.
REQ-035 The bench SHALL cover SCAN with load and sel_in=2 at dwell=2 -> next addr=2, dwell=0, wrap=0; the next increment comes 4 cycles later.
REQ-036 The bench SHALL cover SCAN with hold high for 10 cycles at addr=3 -> addr stays 3, wrap=0; after release, addr goes to 0 with wrap pulse after the remaining dwell.
REQ-037 The bench SHALL cover load and hold asserted together -> load wins, with addr=sel_in.
REQ-038 The bench SHALL cover rst_n pulsed low between edges mid-scan -> y, addr and wrap go to 0 immediately, without waiting for clk; after release, SCAN restarts at addr 0.
